// File: rtl/fft_dif_sequencer_if.sv
// Bus between the DIF FFT sequencer and its surroundings: start/done
// handshake, RAM/ROM read strobes, write-back strobes and FSM debug state.
// Optional readout ports are present only when FFT_SEQ_BITREV_READOUT_EN is defined.
interface fft_dif_sequencer_if #(
  parameter int LOG2N = 3
);
  localparam int SW = $clog2(LOG2N);

  // Handshake: start is a level that is acted on only while the sequencer is
  // idle (busy=0 and done=0); busy stays high for the whole transform; done
  // is a single-cycle pulse after the last write-back. rd_en / wr_en are
  // qualifying strobes with no back-pressure: the addresses beside them are
  // meaningful only in cycles where the strobe is 1 and read as 0 otherwise.
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [SW-1:0]        stage;
  logic                 rd_en;
  logic [LOG2N-1:0]     rd_addr0;
  logic [LOG2N-1:0]     rd_addr1;
  logic [LOG2N-2:0]     tw_addr;
  logic                 wr_en;
  logic [LOG2N-1:0]     wr_addr0;
  logic [LOG2N-1:0]     wr_addr1;
  logic [2:0]           state_dbg;
`ifdef FFT_SEQ_BITREV_READOUT_EN
  logic                 out_valid;
  logic [LOG2N-1:0]     out_addr;
  logic [LOG2N-1:0]     out_index;
`endif

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_addr,
    output wr_en, wr_addr0, wr_addr1, state_dbg
`ifdef FFT_SEQ_BITREV_READOUT_EN
    , output out_valid, out_addr, out_index
`endif
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_addr,
    input  wr_en, wr_addr0, wr_addr1, state_dbg
`ifdef FFT_SEQ_BITREV_READOUT_EN
    , input out_valid, out_addr, out_index
`endif
  );
endinterface

// File: rtl/fft_dif_sequencer.sv
// Control and address generator for an in-place radix-2 DIF FFT using one
// shared butterfly. Issues read/twiddle addresses per butterfly and delays
// them by MEM_LAT+BFLY_LAT cycles to form aligned write-back strobes.
// Optional macro FFT_SEQ_BITREV_READOUT_EN adds a bit-reversed readout phase.
module fft_dif_sequencer #(
  parameter int LOG2N    = 3,
  parameter int MEM_LAT  = 1,
  parameter int BFLY_LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  fft_dif_sequencer_if.master  bus
);
  localparam int HALF   = (1 << LOG2N) / 2;
  localparam int WB_LAT = MEM_LAT + BFLY_LAT;
  localparam int SW     = $clog2(LOG2N);
  localparam int DW     = $clog2(WB_LAT + 1);

  localparam logic [LOG2N-1:0] LAST_K     = LOG2N'(HALF - 1);
  localparam logic [SW-1:0]    LAST_S     = SW'(LOG2N - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(WB_LAT - 1);
`ifdef FFT_SEQ_BITREV_READOUT_EN
  localparam logic [LOG2N-1:0] LAST_N     = LOG2N'(2 * HALF - 1);
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    READOUT = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [LOG2N-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     drain_q, drain_d;

  logic [WB_LAT-1:0]            wen_q, wen_d;
  logic [WB_LAT-1:0][LOG2N-1:0] wa0_q, wa0_d;
  logic [WB_LAT-1:0][LOG2N-1:0] wa1_q, wa1_d;

  logic              rd_en;
  logic [LOG2N-1:0]  rd_a0, rd_a1, span, mask, j_val;
  logic [LOG2N-2:0]  tw_a;

  // State register, counters and write-back delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      wen_q   <= '0;
      wa0_q   <= '0;
      wa1_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      wen_q   <= wen_d;
      wa0_q   <= wa0_d;
      wa1_q   <= wa1_d;
    end
  end

  // Next-state: stage sweep RUN -> DRAIN per stage, then (readout) -> FINISH
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + LOG2N'(1);
        if (cnt_q == LAST_K) begin
          state_d = DRAIN;
          drain_d = '0;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        // Hold off reads until the stage's last write-back has committed
        drain_d = drain_q + DW'(1);
        if (drain_q == DRAIN_LAST) begin
          cnt_d = '0;
          if (stage_q != LAST_S) begin
            stage_d = stage_q + SW'(1);
            state_d = RUN;
          end else begin
`ifdef FFT_SEQ_BITREV_READOUT_EN
            state_d = READOUT;
`else
            state_d = FINISH;
`endif
          end
        end
      end
`ifdef FFT_SEQ_BITREV_READOUT_EN
      READOUT: begin
        cnt_d = cnt_q + LOG2N'(1);
        if (cnt_q == LAST_N) state_d = FINISH;
      end
`endif
      FINISH: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: status, butterfly addressing from (stage, k), readout addressing
  always_comb begin
    rd_en = (state_q == RUN);
    // span = N >> (s+1); j = k mod span; the group index g sits above j,
    // so shifting those upper bits left by one gives 2*span*g
    span  = LOG2N'(1) << (LAST_S - stage_q);
    mask  = span - LOG2N'(1);
    j_val = cnt_q & mask;
    rd_a0 = '0;
    rd_a1 = '0;
    tw_a  = '0;
    if (rd_en) begin
      rd_a0 = ((cnt_q & ~mask) << 1) | j_val;
      rd_a1 = rd_a0 | span;
      tw_a  = (LOG2N-1)'(j_val << stage_q);
    end
    bus.busy      = (state_q == RUN) || (state_q == DRAIN) || (state_q == READOUT);
    bus.done      = (state_q == FINISH);
    bus.stage     = bus.busy ? stage_q : '0;
    bus.rd_en     = rd_en;
    bus.rd_addr0  = rd_a0;
    bus.rd_addr1  = rd_a1;
    bus.tw_addr   = tw_a;
    bus.wr_en     = wen_q[WB_LAT-1];
    bus.wr_addr0  = wa0_q[WB_LAT-1];
    bus.wr_addr1  = wa1_q[WB_LAT-1];
    bus.state_dbg = state_q;
`ifdef FFT_SEQ_BITREV_READOUT_EN
    bus.out_valid = (state_q == READOUT);
    bus.out_index = '0;
    bus.out_addr  = '0;
    if (state_q == READOUT) begin
      bus.out_index = cnt_q;
      for (int b = 0; b < LOG2N; b++) bus.out_addr[b] = cnt_q[LOG2N-1-b];
    end
`endif
  end

  // Delay line: read strobe and addresses shift toward the write-back port
  always_comb begin
    wen_d    = '0;
    wa0_d    = '0;
    wa1_d    = '0;
    wen_d[0] = rd_en;
    wa0_d[0] = rd_a0;
    wa1_d[0] = rd_a1;
    for (int i = 1; i < WB_LAT; i++) begin
      wen_d[i] = wen_q[i-1];
      wa0_d[i] = wa0_q[i-1];
      wa1_d[i] = wa1_q[i-1];
    end
  end
endmodule

// File: tb/tb_fft_dif_sequencer.sv
// Self-checking bench for fft_dif_sequencer: a cycle-indexed reference model
// derived from the FFT stage arithmetic, randomized gaps / start noise /
// reset points, and a write-back scoreboard. Honours FFT_SEQ_BITREV_READOUT_EN.
module tb_fft_dif_sequencer;
  localparam int LOG2N    = 3;
  localparam int MEM_LAT  = 1;
  localparam int BFLY_LAT = 2;
  localparam int N        = 1 << LOG2N;
  localparam int HALF     = N / 2;
  localparam int WB       = MEM_LAT + BFLY_LAT;
  localparam int P        = HALF + WB;
  localparam int TOTAL    = LOG2N * P;
  localparam int SW       = $clog2(LOG2N);
`ifdef FFT_SEQ_BITREV_READOUT_EN
  localparam int RO_LEN   = N;
`else
  localparam int RO_LEN   = 0;
`endif
  localparam int DONE_C   = TOTAL + RO_LEN + 1;

  typedef struct {
    logic             rd;
    logic [LOG2N-1:0] a0;
    logic [LOG2N-1:0] a1;
    logic [LOG2N-2:0] tw;
    logic [SW-1:0]    st;
    logic             busy;
    logic             done;
    logic             wr;
    logic [LOG2N-1:0] wa0;
    logic [LOG2N-1:0] wa1;
    logic             ov;
    logic [LOG2N-1:0] oa;
    logic [LOG2N-1:0] oi;
  } exp_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_dif_sequencer_if #(.LOG2N(LOG2N)) bus();

  fft_dif_sequencer #(
    .LOG2N(LOG2N), .MEM_LAT(MEM_LAT), .BFLY_LAT(BFLY_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [2*LOG2N-1:0] exp_q[$];

  // Reference: the read issued c cycles after start was sampled (c>=1)
  function automatic void read_at(input int c, output bit rd, output int a0,
                                  output int a1, output int tw, output int st);
    int off, span, j, g;
    rd = 0; a0 = 0; a1 = 0; tw = 0; st = 0;
    if (c >= 1 && c <= TOTAL) begin
      st  = (c - 1) / P;
      off = (c - 1) % P;
      if (off < HALF) begin
        span = N >> (st + 1);
        j    = off % span;
        g    = off / span;
        a0   = 2 * span * g + j;
        a1   = a0 + span;
        tw   = (j << st) % HALF;
        rd   = 1;
      end
    end
  endfunction

  function automatic int bitrev(input int n);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (((n >> b) & 1) == 1) r |= 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  function automatic exp_t model(input int c);
    exp_t e;
    bit r;
    int a0, a1, tw, st;
    e = '{default: '0};
    read_at(c, r, a0, a1, tw, st);
    e.rd = r; e.a0 = LOG2N'(a0); e.a1 = LOG2N'(a1); e.tw = (LOG2N-1)'(tw);
    if (c >= 1 && c <= TOTAL) begin
      e.busy = 1'b1;
      e.st   = SW'(st);
    end
`ifdef FFT_SEQ_BITREV_READOUT_EN
    if (c > TOTAL && c <= TOTAL + N) begin
      e.busy = 1'b1;
      e.st   = SW'(LOG2N - 1);
      e.ov   = 1'b1;
      e.oi   = LOG2N'(c - TOTAL - 1);
      e.oa   = LOG2N'(bitrev(c - TOTAL - 1));
    end
`endif
    e.done = (c == DONE_C);
    read_at(c - WB, r, a0, a1, tw, st);
    e.wr = r; e.wa0 = LOG2N'(a0); e.wa1 = LOG2N'(a1);
    return e;
  endfunction

  // Driver tasks
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.stage} !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold got=%b exp=0", {bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.stage});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL idle_quiet i=%0d got=%b exp=0000", i, {bus.busy, bus.done, bus.rd_en, bus.wr_en});
      end
    end
  endtask

  // Full transform, every cycle against the model; optional start noise while busy
  task automatic test_transform(input bit noise, input string tag);
    exp_t e;
    int wr_cnt = 0;
    logic [2*LOG2N-1:0] got_w;
    exp_q.delete();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    pulse_start();
    for (int c = 1; c <= DONE_C + 2; c++) begin
      e = model(c);
      tests_run++;
      if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== {e.busy, e.done, e.rd, e.wr}) begin
        tests_failed++;
        $display("FAIL %s_ctrl c=%0d got=%b exp=%b", tag, c,
                 {bus.busy, bus.done, bus.rd_en, bus.wr_en}, {e.busy, e.done, e.rd, e.wr});
      end
      tests_run++;
      if ({bus.rd_addr0, bus.rd_addr1, bus.tw_addr} !== {e.a0, e.a1, e.tw}) begin
        tests_failed++;
        $display("FAIL %s_rd c=%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", tag, c,
                 bus.rd_addr0, bus.rd_addr1, bus.tw_addr, e.a0, e.a1, e.tw);
      end
      if (e.busy) begin
        tests_run++;
        if (bus.stage !== e.st) begin
          tests_failed++;
          $display("FAIL %s_stage c=%0d got=%0d exp=%0d", tag, c, bus.stage, e.st);
        end
      end
`ifdef FFT_SEQ_BITREV_READOUT_EN
      tests_run++;
      if ({bus.out_valid, bus.out_index, bus.out_addr} !== {e.ov, e.oi, e.oa}) begin
        tests_failed++;
        $display("FAIL %s_readout c=%0d got=%b,%0d,%0d exp=%b,%0d,%0d", tag, c,
                 bus.out_valid, bus.out_index, bus.out_addr, e.ov, e.oi, e.oa);
      end
`endif
      if (e.rd) exp_q.push_back({e.a0, e.a1});
      if (bus.wr_en === 1'b1) begin
        wr_cnt++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s_wr_unexpected c=%0d got=%0d,%0d exp=none", tag, c, bus.wr_addr0, bus.wr_addr1);
        end else begin
          got_w = exp_q.pop_front();
          if ({bus.wr_addr0, bus.wr_addr1} !== got_w) begin
            tests_failed++;
            $display("FAIL %s_wr_addr c=%0d got=%h exp=%h", tag, c, {bus.wr_addr0, bus.wr_addr1}, got_w);
          end
        end
      end
      bus.start = (noise && e.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    tests_run++;
    if (wr_cnt != LOG2N * HALF || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_wr_total got=%0d left=%0d exp=%0d left=0", tag, wr_cnt, exp_q.size(), LOG2N * HALF);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int abort_c = P + $urandom_range(1, HALF);
    pulse_start();
    for (int c = 1; c < abort_c; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.stage, bus.rd_addr0, bus.rd_addr1,
         bus.tw_addr, bus.wr_addr0, bus.wr_addr1} !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs got=%b,%b,%b,%b,%0d exp=all_zero", bus.busy, bus.done,
               bus.rd_en, bus.wr_en, bus.stage);
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.done, bus.wr_en} !== 3'b000) begin
        tests_failed++;
        $display("FAIL abort_no_done i=%0d got=%b exp=000", i, {bus.busy, bus.done, bus.wr_en});
      end
    end
    pulse_start();
    for (int c = 1; c <= P; c++) begin
      e = model(c);
      tests_run++;
      if ({bus.rd_en, bus.rd_addr0, bus.rd_addr1, bus.tw_addr, bus.stage} !==
          {e.rd, e.a0, e.a1, e.tw, e.st}) begin
        tests_failed++;
        $display("FAIL restart_stage0 c=%0d got=%b,%0d,%0d,%0d exp=%b,%0d,%0d,%0d", c,
                 bus.rd_en, bus.rd_addr0, bus.rd_addr1, bus.tw_addr, e.rd, e.a0, e.a1, e.tw);
      end
      @(negedge clk);
    end
    repeat (DONE_C) @(negedge clk);
  endtask

  // start held high: ignored in FINISH, accepted on the following idle cycle
  task automatic test_back_to_back();
    exp_t e;
    bus.start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 2 * DONE_C + 2; c++) begin
      e = (c <= DONE_C + 1) ? model(c) : model(c - DONE_C - 1);
      tests_run++;
      if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr0, bus.rd_addr1} !==
          {e.busy, e.done, e.rd, e.wr, e.a0, e.a1}) begin
        tests_failed++;
        $display("FAIL b2b c=%0d got=%b%b%b%b,%0d,%0d exp=%b%b%b%b,%0d,%0d", c,
                 bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr0, bus.rd_addr1,
                 e.busy, e.done, e.rd, e.wr, e.a0, e.a1);
      end
      if (c == DONE_C + 2) bus.start = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_transform(1'b0, "plain");
    test_transform(1'b1, "start_noise");
    test_reset_mid_run();
    test_back_to_back();
    test_transform(1'b1, "final");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fft_dif_sequencer.md
Name: fft_dif_sequencer

Overview:
- Control and address generator for an in-place radix-2 DIF FFT built around one shared butterfly_dif instance.
- The butterfly has 2-cycle latency and packs {re,im}; this block does not touch that data.
- Per butterfly it issues dual-port RAM read addresses and a twiddle-ROM address, then delays the same addresses to produce write-back strobes aligned with the butterfly output.
- Sits between the top-level start/done handshake and the sample RAM, twiddle ROM and butterfly.

Parameters:
- LOG2N, 3: log2 of FFT size N; legal range 2..12.
- MEM_LAT, 1: read latency of sample RAM and twiddle ROM, in cycles.
- BFLY_LAT, 2: butterfly_dif pipeline latency, in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  begin a transform; sampled in IDLE only.
- busy  out  1  high while a transform is in progress.
- done  out  1  one-cycle pulse at completion.
- stage  out  $clog2(LOG2N)  current stage index s.
- rd_en  out  1  read strobe for the RAM pair and the twiddle ROM.
- rd_addr0  out  LOG2N  RAM read address for x0.
- rd_addr1  out  LOG2N  RAM read address for x1.
- tw_addr  out  LOG2N-1  twiddle ROM address (W_N^tw_addr).
- wr_en  out  1  write-back strobe.
- wr_addr0  out  LOG2N  write address for out_x0.
- wr_addr1  out  LOG2N  write address for out_x1.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset clears every output to 0, the FSM goes to IDLE, and all delay-line valid bits clear. Reset mid-transform abandons the transform with no done pulse; wr_en is 0 from the next cycle.
- Definitions: WB_LAT = MEM_LAT + BFLY_LAT. Butterfly counter k runs 0..N/2-1. span = N >> (s+1). j = k mod span. g = k / span.
- Addressing, combinational from s and k:
  - rd_addr0 = 2*span*g + j.
  - rd_addr1 = rd_addr0 + span.
  - tw_addr = j << s, truncated to LOG2N-1 bits.
- FSM states:
  - IDLE: start=1 -> RUN with s=0, k=0, busy=1 next cycle. Otherwise stay.
  - RUN: rd_en=1 every cycle and k increments. When k=N/2-1 -> DRAIN with drain counter = 0.
  - DRAIN: rd_en=0 for exactly WB_LAT cycles so the last write of a stage commits before the next stage's first read (read-after-write across stages).
    - At the end of DRAIN, if s < LOG2N-1: s increments, k=0, -> RUN.
    - Otherwise -> FINISH.
  - FINISH: done=1 for one cycle, busy=0, -> IDLE.
- Write-back: {rd_en, rd_addr0, rd_addr1} pass through a WB_LAT-deep register delay line to become {wr_en, wr_addr0, wr_addr1}. wr_en is therefore high exactly WB_LAT cycles after the matching rd_en.
- stage changes only at a DRAIN->RUN transition. It holds its value during DRAIN and reads 0 in IDLE.
- start while busy=1 is ignored. start in the same cycle as the FINISH->IDLE transition is also ignored; it is accepted the cycle after.
- Cycle count from the cycle after start to done, inclusive: LOG2N*(N/2 + WB_LAT) + 1. For N=8 with defaults this is 22.
- Address outputs are don't-care when their strobe is low; the implementation drives them to 0 in that case.

Optional Feature:
- Macro: FFT_SEQ_BITREV_READOUT_EN.
- Defined:
  - Adds outputs out_valid (1), out_addr (LOG2N) and out_index (LOG2N).
  - After the last DRAIN, the FSM enters READOUT for N cycles. In that state out_valid=1, out_index=n and out_addr=bitreverse(n) for n=0..N-1, giving natural-order output.
  - Then FINISH. busy stays high through READOUT.
  - Total cycle count becomes LOG2N*(N/2+WB_LAT)+N+1.
- Undefined: the ports are absent and DRAIN goes directly to FINISH.

Test Plan:
- Reset/idle: hold rst 3 cycles, release, no start -> busy, done, rd_en and wr_en all stay 0 for 20 cycles.
- N=8 stage 0: pulse start -> rd (addr0,addr1,tw) sequence is (0,4,0) (1,5,1) (2,6,2) (3,7,3) on 4 consecutive cycles with stage=0.
- N=8 stages 1–2:
  - Stage 1 sequence is (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2 sequence is (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Exactly 3 idle rd_en cycles separate each stage.
- Write alignment: for every rd_en at cycle t, wr_en=1 at t+3 with identical addresses. There are 12 wr_en pulses in total, and done pulses at cycle 22 after start.
- Start while busy, and reset mid-run:
  - Re-pulsing start during stage 1 changes no address sequence.
  - Asserting rst during stage 1 -> all outputs 0 on the next cycle and no done pulse.
  - A fresh start then reproduces the stage-0 sequence.
- With FFT_SEQ_BITREV_READOUT_EN, N=8 -> out_addr sequence 0,4,2,6,1,5,3,7 with out_index 0..7, then done.
